butterfly1_8_reg: RTL and testbench
===================================

BUTTERFLY1_8_REG -- requirements
Module: butterfly1_8_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  row i_0..i_7 valid this cycle
- enable  in  1  1 = butterfly, 0 = bypass; sampled per block
- inverse  in  1  1 = inverse pairing, 0 = forward pairing; sampled per block
- i_0..i_7  in  16 each, signed  permuted row from the upstream 8-point permute stage
- valid_o  out  1  o_0..o_7 valid
- block_done_o  out  1  high with valid_o on the 8th row of a block
- o_0..o_7  out  16 each, signed  butterfly result

Function
REQ-003 The block SHALL accept one row on every cycle where valid_i=1, with no backpressure.
REQ-004 Latency SHALL be exactly 2 cycles: stage 1 registers the 17-bit sums and differences, stage 2 registers the 16-bit result and valid_o.
REQ-005 Forward mode (inverse=0, enable=1) SHALL compute, for k=0..3, o_k = i_k + i_(7-k).
REQ-006 Forward mode SHALL also compute, for k=4..7, o_k = i_(7-k) - i_k.
REQ-007 Inverse mode (inverse=1, enable=1) SHALL compute, for k=0..3, o_k = i_k + i_(k+4) and o_(k+4) = i_k - i_(k+4).
REQ-008 Bypass (enable=0) SHALL give o_k = i_k, regardless of inverse.
REQ-009 All arithmetic SHALL be signed at 17 bits, reduced to 16 bits at stage 2 as set out in Configuration.
REQ-010 A 3-bit row counter SHALL increment on each accepted row and wrap from 7 to 0.
REQ-011 enable and inverse SHALL be captured into mode registers when a row is accepted with row counter = 0.
REQ-012 Rows 1..7 of the block SHALL use the captured mode; changes to enable or inverse mid-block SHALL be ignored.
REQ-013 On the row-0 cycle, the live enable and inverse inputs SHALL apply to that row.
REQ-014 block_done_o SHALL pulse for one cycle, coincident with valid_o, for the row accepted at counter = 7.
REQ-015 Gaps (valid_i=0) SHALL NOT advance the counter; a block MAY span any number of cycles.
REQ-016 Pipeline registers SHALL hold their value when valid is low.
REQ-017 valid_o SHALL be 0 in any cycle without a corresponding accepted row.

Reset
REQ-018 On rst=1 at a clock edge, the following SHALL be cleared: valid_o, block_done_o, both stage valids, the row counter, the mode registers (enable=0, inverse=0) and o_0..o_7.
REQ-019 Reset mid-block SHALL discard in-flight rows; no valid_o SHALL appear for them.
REQ-020 The next accepted row after reset SHALL be treated as row 0.
REQ-021 rst SHALL take priority over valid_i in the same cycle.

Configuration
REQ-022 Macro BUTTERFLY1_8_SAT_EN SHALL select how 17-bit results are reduced to 16 bits.
REQ-023 With BUTTERFLY1_8_SAT_EN defined, each 17-bit result SHALL be clamped to [-32768, 32767].
REQ-024 Without BUTTERFLY1_8_SAT_EN, each result SHALL keep its low 16 bits (two's-complement wrap).
REQ-025 Latency and interface SHALL be identical in both builds.

Verification
REQ-026 Forward row, enable=1, inverse=0, i_0..i_7 = 1,2,3,4,5,6,7,8 -> 2 cycles later o = 9,9,9,9,-1,-3,-5,-7, valid_o=1.
REQ-027 Inverse row, enable=1, inverse=1, i = 1,2,3,4,5,6,7,8 -> o = 6,8,10,12,-4,-4,-4,-4.
REQ-028 Eight back-to-back rows, with inverse toggled on row 3 -> all eight rows use the row-0 mode; block_done_o=1 only with the 8th valid_o.
REQ-029 i_0 = 32767, i_7 = 1, forward -> o_0 = 32767 with BUTTERFLY1_8_SAT_EN defined, o_0 = -32768 without it.
REQ-030 rst asserted one cycle after row 5 of a block -> no valid_o for rows still in flight; the next row is row 0 and block_done_o follows 8 rows later.
REQ-031 enable=0, rows interleaved with valid_i=0 gaps -> o equals i delayed 2 cycles; the counter advances only on valid rows.

Source files
------------

// File: rtl/butterfly1_8_reg.sv
// 8-lane two-stage butterfly (forward / inverse pairing / bypass) with per-block mode capture.
// Define BUTTERFLY1_8_SAT_EN to clamp 17-bit results to 16 bits instead of wrapping.

module butterfly1_8_lane (
  input  logic signed [16:0] x_i,
  output logic signed [15:0] y_o
);
`ifdef BUTTERFLY1_8_SAT_EN
  always_comb begin
    if (x_i > 17'sh07fff)      y_o = 16'sh7fff;
    else if (x_i < 17'sh18000) y_o = 16'sh8000;
    else                       y_o = 16'(x_i);
  end
`else
  assign y_o = 16'(x_i);
`endif
endmodule

module butterfly1_8_reg (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               enable,
  input  logic               inverse,
  input  logic signed [15:0] i_0,
  input  logic signed [15:0] i_1,
  input  logic signed [15:0] i_2,
  input  logic signed [15:0] i_3,
  input  logic signed [15:0] i_4,
  input  logic signed [15:0] i_5,
  input  logic signed [15:0] i_6,
  input  logic signed [15:0] i_7,
  output logic               valid_o,
  output logic               block_done_o,
  output logic signed [15:0] o_0,
  output logic signed [15:0] o_1,
  output logic signed [15:0] o_2,
  output logic signed [15:0] o_3,
  output logic signed [15:0] o_4,
  output logic signed [15:0] o_5,
  output logic signed [15:0] o_6,
  output logic signed [15:0] o_7
);
  localparam int NUM_LANES = 8;
  localparam int HALF      = NUM_LANES / 2;
  localparam int STAGES    = 2;

  logic [NUM_LANES-1:0][15:0] in_w;
  logic [NUM_LANES-1:0][16:0] s1_d, s1_q;
  logic [NUM_LANES-1:0][15:0] red_w, o_q;
  logic [STAGES:1]            vld_pipe_q, done_pipe_q;
  logic [2:0]                 cnt_q, cnt_d;
  logic                       mode_en_q, mode_inv_q;
  logic                       eff_en, eff_inv;

  assign in_w = {i_7, i_6, i_5, i_4, i_3, i_2, i_1, i_0};

  function automatic logic signed [16:0] sx(input logic [15:0] x);
    return {x[15], x};
  endfunction

  // Row 0 uses the live mode inputs; later rows of the block use the captured copy.
  always_comb begin
    eff_en  = (cnt_q == 3'd0) ? enable  : mode_en_q;
    eff_inv = (cnt_q == 3'd0) ? inverse : mode_inv_q;
    cnt_d   = cnt_q + 3'd1;
    s1_d    = '0;
    for (int k = 0; k < HALF; k++) begin
      if (!eff_en) begin
        s1_d[k]      = sx(in_w[k]);
        s1_d[k+HALF] = sx(in_w[k+HALF]);
      end else if (eff_inv) begin
        s1_d[k]      = sx(in_w[k]) + sx(in_w[k+HALF]);
        s1_d[k+HALF] = sx(in_w[k]) - sx(in_w[k+HALF]);
      end else begin
        s1_d[k]             = sx(in_w[k]) + sx(in_w[NUM_LANES-1-k]);
        s1_d[NUM_LANES-1-k] = sx(in_w[k]) - sx(in_w[NUM_LANES-1-k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      mode_en_q   <= 1'b0;
      mode_inv_q  <= 1'b0;
      vld_pipe_q  <= '0;
      done_pipe_q <= '0;
      s1_q        <= '0;
      o_q         <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[STAGES-1:1], valid_i};
      done_pipe_q <= {done_pipe_q[STAGES-1:1], valid_i && (cnt_q == 3'd7)};
      if (valid_i) begin
        cnt_q <= cnt_d;
        s1_q  <= s1_d;
        if (cnt_q == 3'd0) begin
          mode_en_q  <= enable;
          mode_inv_q <= inverse;
        end
      end
      if (vld_pipe_q[1]) o_q <= red_w;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    butterfly1_8_lane u_lane (.x_i(s1_q[g]), .y_o(red_w[g]));
  end

  assign valid_o      = vld_pipe_q[STAGES];
  assign block_done_o = done_pipe_q[STAGES];
  assign o_0 = o_q[0];
  assign o_1 = o_q[1];
  assign o_2 = o_q[2];
  assign o_3 = o_q[3];
  assign o_4 = o_q[4];
  assign o_5 = o_q[5];
  assign o_6 = o_q[6];
  assign o_7 = o_q[7];
endmodule

// File: tb/tb_butterfly1_8_reg.sv
// Directed bench for butterfly1_8_reg: hand vectors plus a small row/mode model for pipelined runs.
module tb_butterfly1_8_reg;
  logic clk = 1'b0;
  logic rst, valid_i, enable, inverse;
  logic signed [15:0] i_r [8];
  logic signed [15:0] o_w [8];
  logic valid_o, block_done_o;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  butterfly1_8_reg dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .enable(enable), .inverse(inverse),
    .i_0(i_r[0]), .i_1(i_r[1]), .i_2(i_r[2]), .i_3(i_r[3]),
    .i_4(i_r[4]), .i_5(i_r[5]), .i_6(i_r[6]), .i_7(i_r[7]),
    .valid_o(valid_o), .block_done_o(block_done_o),
    .o_0(o_w[0]), .o_1(o_w[1]), .o_2(o_w[2]), .o_3(o_w[3]),
    .o_4(o_w[4]), .o_5(o_w[5]), .o_6(o_w[6]), .o_7(o_w[7])
  );

  // model state: block counter, captured mode, row in flight, last emitted row
  int   m_cnt;
  logic m_en, m_inv;
  logic pv, pd;
  int   prow [8];
  int   last_o [8];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int red(input int x);
`ifdef BUTTERFLY1_8_SAT_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    logic signed [15:0] t;
    t = x[15:0];
    return int'(t);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, then check the output belonging to the previous cycle's row.
  task automatic push(input logic v, input logic en, input logic inv, input int r[8]);
    logic e_en, e_inv;
    int x [8];
    valid_i = v; enable = en; inverse = inv;
    for (int k = 0; k < 8; k++) i_r[k] = 16'(r[k]);
    step();
    chk("valid_o", int'(valid_o), int'(pv));
    chk("block_done_o", int'(block_done_o), int'(pd));
    for (int k = 0; k < 8; k++)
      chk($sformatf("o_%0d", k), int'(o_w[k]), pv ? prow[k] : last_o[k]);
    if (pv) last_o = prow;
    pv = v; pd = 1'b0;
    if (v) begin
      e_en  = (m_cnt == 0) ? en  : m_en;
      e_inv = (m_cnt == 0) ? inv : m_inv;
      if (m_cnt == 0) begin m_en = en; m_inv = inv; end
      pd = (m_cnt == 7);
      for (int k = 0; k < 4; k++) begin
        if (!e_en) begin
          x[k] = r[k]; x[k+4] = r[k+4];
        end else if (e_inv) begin
          x[k] = red(r[k] + r[k+4]); x[k+4] = red(r[k] - r[k+4]);
        end else begin
          x[k] = red(r[k] + r[7-k]); x[7-k] = red(r[k] - r[7-k]);
        end
      end
      prow = x;
      m_cnt = (m_cnt + 1) % 8;
    end
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1; valid_i = v;
    step();
    chk("rst valid_o", int'(valid_o), 0);
    chk("rst block_done_o", int'(block_done_o), 0);
    for (int k = 0; k < 8; k++) chk($sformatf("rst o_%0d", k), int'(o_w[k]), 0);
    rst = 1'b0; valid_i = 1'b0;
    m_cnt = 0; m_en = 1'b0; m_inv = 1'b0; pv = 1'b0; pd = 1'b0;
    for (int k = 0; k < 8; k++) begin last_o[k] = 0; prow[k] = 0; end
  endtask

  initial begin
    int z [8];
    int row [8];
    int e [8];
    rst = 1'b1; valid_i = 1'b0; enable = 1'b0; inverse = 1'b0;
    for (int k = 0; k < 8; k++) begin i_r[k] = '0; z[k] = 0; end

    // reset state
    do_reset(1'b0);

    // forward hand vector; output must not appear after one edge
    row = '{1, 2, 3, 4, 5, 6, 7, 8};
    push(1'b1, 1'b1, 1'b0, row);
    push(1'b0, 1'b1, 1'b0, z);
    e = '{9, 9, 9, 9, -1, -3, -5, -7};
    for (int k = 0; k < 8; k++) chk($sformatf("fwd o_%0d", k), int'(o_w[k]), e[k]);

    // inverse hand vector
    do_reset(1'b0);
    push(1'b1, 1'b1, 1'b1, row);
    push(1'b0, 1'b1, 1'b1, z);
    e = '{6, 8, 10, 12, -4, -4, -4, -4};
    for (int k = 0; k < 8; k++) chk($sformatf("inv o_%0d", k), int'(o_w[k]), e[k]);

    // eight back-to-back rows, inverse raised from row 3 on: whole block stays forward
    do_reset(1'b0);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) row[k] = r * 100 + k * 13 - 50;
      push(1'b1, 1'b1, (r >= 3), row);
    end
    push(1'b0, 1'b1, 1'b1, z);
    chk("blk done on 8th", int'(block_done_o), 1);
    push(1'b0, 1'b1, 1'b1, z);

    // 17-bit overflow at both ends
    do_reset(1'b0);
    row = '{32767, 0, 0, 0, 0, 0, 0, 1};
    push(1'b1, 1'b1, 1'b0, row);
    push(1'b0, 1'b1, 1'b0, z);
`ifdef BUTTERFLY1_8_SAT_EN
    chk("ovf o_0", int'(o_w[0]), 32767);
`else
    chk("ovf o_0", int'(o_w[0]), -32768);
`endif
    chk("ovf o_7", int'(o_w[7]), 32766);
    row = '{-32768, 0, 0, 0, 0, 0, 0, -1};
    push(1'b1, 1'b1, 1'b0, row);
    push(1'b0, 1'b1, 1'b0, z);
`ifdef BUTTERFLY1_8_SAT_EN
    chk("unf o_0", int'(o_w[0]), -32768);
`else
    chk("unf o_0", int'(o_w[0]), 32767);
`endif

    // reset one cycle after row 5, with valid_i high during reset
    do_reset(1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) row[k] = r * 7 + k;
      push(1'b1, 1'b1, 1'b0, row);
    end
    do_reset(1'b1);
    push(1'b0, 1'b0, 1'b0, z);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) row[k] = 300 - r * 11 + k * 5;
      push(1'b1, 1'b1, (r == 0), row);
    end
    push(1'b0, 1'b0, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);

    // bypass with gaps; enable toggled mid-block must be ignored
    do_reset(1'b0);
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 8; k++) row[k] = k * 1000 - c * 37 + 5;
      push((c % 3 != 1), (c >= 4 && c <= 7), 1'b1, row);
    end
    push(1'b0, 1'b0, 1'b0, z);
    push(1'b0, 1'b0, 1'b0, z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
